regfile_sb: RTL and testbench

- Parametrised successor to the single-cycle core's 32x32 register file, for the pipelined core.
- Adds a second write port for ALU and load writeback.
- Adds a configurable number of read ports.
- Adds a per-register pending-write scoreboard so the hazard unit can stall on in-flight producers.
- Sits between decode (read and reserve) and writeback (write and release).

---
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Pipelined-core register file: two write ports, NRD read ports and a pending-write scoreboard.
// Optional same-cycle write forwarding on the read ports is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int NRD   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_ready,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   input  logic                we0,
   input  logic [AW-1:0]       wa0,
   input  logic [XLEN-1:0]     wd0,
   input  logic                we1,
   input  logic [AW-1:0]       wa1,
   input  logic [XLEN-1:0]     wd1,
   output logic [AW:0]         pend_cnt
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pendNext;
   logic [AW:0]      pendCnt;
   logic             wr0;
   logic             wr1;

   function automatic logic [AW:0] popCount(input logic [NREGS-1:0] bits);
      logic [AW:0] n;
      n = '0;
      for (int i = 0; i < NREGS; i++) begin
         n = n + {{AW{1'b0}}, bits[i]};
      end
      return n;
   endfunction

   // Register 0 is never a write target, so it stays zero from reset onward.
   assign wr0 = we0 && (wa0 != '0);
   assign wr1 = we1 && (wa1 != '0);

   // A reserve beats a same-cycle release: a newer producer has just issued.
   always_comb begin
      pendNext = pending;
      for (int r = 1; r < NREGS; r++) begin
         if ((wr0 && wa0 == AW'(r)) || (wr1 && wa1 == AW'(r))) begin
            pendNext[r] = 1'b0;
         end
         if (rsv_en && rsv_addr == AW'(r)) begin
            pendNext[r] = 1'b1;
         end
      end
      pendNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         pending <= '0;
         pendCnt <= '0;
      end else begin
         if (wr0) begin
            regs[wa0] <= wd0;
         end
         if (wr1) begin
            regs[wa1] <= wd1;
         end
         pending <= pendNext;
         pendCnt <= popCount(pendNext);
      end
   end

   assign pend_cnt = pendCnt;

   for (genvar i = 0; i < NRD; i++) begin : gRead
      logic [AW-1:0]   rdAddr;
      logic [XLEN-1:0] rdVal;
      logic            rdRdy;

      assign rdAddr = rd_addr[i*AW +: AW];

      always_comb begin
         rdVal = regs[rdAddr];
         rdRdy = ~pending[rdAddr];
`ifdef REGFILE_SB_BYPASS_EN
         if (rdAddr != '0) begin
            if (wr1 && wa1 == rdAddr) begin
               rdVal = wd1;
            end else if (wr0 && wa0 == rdAddr) begin
               rdVal = wd0;
            end
            if (((wr0 && wa0 == rdAddr) || (wr1 && wa1 == rdAddr)) &&
                !(rsv_en && rsv_addr == rdAddr)) begin
               rdRdy = 1'b1;
            end
         end
`endif
      end

      assign rd_data[i*XLEN +: XLEN] = rdVal;
      assign rd_ready[i]             = rdRdy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand sequences, then random traffic against a reference model.
module tb_regfile_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                we0;
   logic [AW-1:0]       wa0;
   logic [XLEN-1:0]     wd0;
   logic                we1;
   logic [AW-1:0]       wa1;
   logic [XLEN-1:0]     wd1;
   logic [AW:0]         pend_cnt;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .pend_cnt(pend_cnt)
   );

   typedef struct {
      logic            rstN;
      logic            rsvEn;
      logic [AW-1:0]   rsvA;
      logic            w0;
      logic [AW-1:0]   a0;
      logic [XLEN-1:0] d0;
      logic            w1;
      logic [AW-1:0]   a1;
      logic [XLEN-1:0] d1;
      logic [AW-1:0]   ra0;
      logic [AW-1:0]   ra1;
      logic [XLEN-1:0] expD0;
      logic            expR0;
      logic [XLEN-1:0] expD1;
      logic            expR1;
      logic [AW:0]     expCnt;
   } vec_t;

   vec_t vecs [17];

   int nChecks = 0;
   int nErrors = 0;

   logic [XLEN-1:0] mRegs [NREGS];
   bit              mPend [NREGS];

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setIn(input logic r, input logic re, input logic [AW-1:0] ra,
                        input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                        input logic [AW-1:0] p0, input logic [AW-1:0] p1);
      rst = r; rsv_en = re; rsv_addr = ra;
      we0 = e0; wa0 = a0; wd0 = d0;
      we1 = e1; wa1 = a1; wd1 = d1;
      rd_addr = {p1, p0};
   endtask

   task automatic idleIn(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
      setIn(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, p0, p1);
   endtask

   // Advance one clock and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mRegs[r] = '0;
            mPend[r] = 1'b0;
         end
      end else begin
         if (we0 && wa0 != 0) mRegs[wa0] = wd0;
         if (we1 && wa1 != 0) mRegs[wa1] = wd1;
         if (we0 && wa0 != 0) mPend[wa0] = 1'b0;
         if (we1 && wa1 != 0) mPend[wa1] = 1'b0;
         if (rsv_en && rsv_addr != 0) mPend[rsv_addr] = 1'b1;
      end
      #1;
   endtask

   function automatic logic [XLEN-1:0] expData(input int a);
      logic [XLEN-1:0] v;
      v = mRegs[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (a != 0) begin
         if (we1 && wa1 == a) v = wd1;
         else if (we0 && wa0 == a) v = wd0;
      end
`endif
      return v;
   endfunction

   function automatic logic expReady(input int a);
      logic r;
      r = !mPend[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (a != 0 && ((we0 && wa0 == a) || (we1 && wa1 == a)) && !(rsv_en && rsv_addr == a)) r = 1'b1;
`endif
      return r;
   endfunction

   function automatic int expCount();
      int n;
      n = 0;
      for (int r = 0; r < NREGS; r++) n += int'(mPend[r]);
      return n;
   endfunction

   task automatic modelCheck();
      for (int i = 0; i < NRD; i++) begin
         int a;
         a = int'(rd_addr[i*AW +: AW]);
         chk($sformatf("rnd_data%0d_r%0d", i, a), rd_data[i*XLEN +: XLEN], expData(a));
         chk($sformatf("rnd_ready%0d_r%0d", i, a), {31'b0, rd_ready[i]}, {31'b0, expReady(a)});
      end
      chk("rnd_pend_cnt", {26'b0, pend_cnt}, XLEN'(expCount()));
   endtask

   initial begin
      //            rst rsv rA  w0 a0 d0            w1 a1 d1            r0 r1 eD0           eR eD1           eR cnt
      vecs[0]  = '{1, 0, 0,  1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 2, 0,            1, 0,            1, 0};
      vecs[1]  = '{0, 0, 0,  0, 0, 0,            0, 0, 0,            5, 0, 32'hDEADBEEF, 1, 0,            1, 0};
      vecs[2]  = '{0, 0, 0,  0, 0, 0,            0, 0, 0,            5, 0, 0,            1, 0,            1, 0};
      vecs[3]  = '{1, 0, 0,  0, 0, 0,            0, 0, 0,            5, 1, 0,            1, 0,            1, 0};
      vecs[4]  = '{1, 1, 0,  1, 0, 32'h12345678, 0, 0, 0,            0, 0, 0,            1, 0,            1, 0};
      vecs[5]  = '{1, 0, 0,  1, 7, 32'hAAAA0000, 1, 7, 32'h0000BBBB, 0, 3, 0,            1, 0,            1, 0};
      vecs[6]  = '{1, 1, 3,  0, 0, 0,            0, 0, 0,            7, 3, 32'h0000BBBB, 1, 0,            1, 0};
      vecs[7]  = '{1, 0, 0,  0, 0, 0,            0, 0, 0,            3, 0, 0,            0, 0,            1, 1};
      vecs[8]  = '{1, 0, 0,  0, 0, 0,            1, 3, 32'h55,       0, 7, 0,            1, 32'h0000BBBB, 1, 1};
      vecs[9]  = '{1, 0, 0,  0, 0, 0,            0, 0, 0,            3, 7, 32'h55,       1, 32'h0000BBBB, 1, 0};
      vecs[10] = '{1, 1, 9,  0, 0, 0,            0, 0, 0,            9, 0, 0,            1, 0,            1, 0};
      vecs[11] = '{1, 1, 9,  1, 9, 32'h99,       0, 0, 0,            3, 0, 32'h55,       1, 0,            1, 1};
      vecs[12] = '{1, 0, 0,  0, 0, 0,            0, 0, 0,            9, 0, 32'h99,       0, 0,            1, 1};
      vecs[13] = '{1, 0, 0,  1, 9, 32'h1,        0, 0, 0,            3, 0, 32'h55,       1, 0,            1, 1};
      vecs[14] = '{1, 0, 0,  0, 0, 0,            0, 0, 0,            9, 0, 32'h1,        1, 0,            1, 0};
      vecs[15] = '{0, 1, 4,  1, 4, 32'h77,       0, 0, 0,            9, 0, 32'h1,        1, 0,            1, 0};
      vecs[16] = '{1, 0, 0,  0, 0, 0,            0, 0, 0,            4, 9, 0,            1, 0,            1, 0};

      setIn(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
      tick();
      tick();

      // Directed vector table: outputs sampled before the row's clock edge.
      for (int v = 0; v < 17; v++) begin
         setIn(vecs[v].rstN, vecs[v].rsvEn, vecs[v].rsvA, vecs[v].w0, vecs[v].a0, vecs[v].d0,
               vecs[v].w1, vecs[v].a1, vecs[v].d1, vecs[v].ra0, vecs[v].ra1);
         #4;
         chk($sformatf("vec%0d_data0", v), rd_data[XLEN-1:0], vecs[v].expD0);
         chk($sformatf("vec%0d_ready0", v), {31'b0, rd_ready[0]}, {31'b0, vecs[v].expR0});
         chk($sformatf("vec%0d_data1", v), rd_data[2*XLEN-1:XLEN], vecs[v].expD1);
         chk($sformatf("vec%0d_ready1", v), {31'b0, rd_ready[1]}, {31'b0, vecs[v].expR1});
         chk($sformatf("vec%0d_pend_cnt", v), {26'b0, pend_cnt}, {26'b0, vecs[v].expCnt});
         tick();
      end

      // Same-cycle read of a register being written.
      setIn(1'b1, 1'b0, '0, 1'b1, 5'd4, 32'h11, 1'b0, '0, '0, '0, '0);
      tick();
      setIn(1'b1, 1'b0, '0, 1'b1, 5'd4, 32'hCAFEF00D, 1'b0, '0, '0, 5'd4, '0);
      #4;
`ifdef REGFILE_SB_BYPASS_EN
      chk("bypass_same_cycle", rd_data[XLEN-1:0], 32'hCAFEF00D);
`else
      chk("nobypass_same_cycle", rd_data[XLEN-1:0], 32'h11);
`endif
      tick();
      idleIn(5'd4, '0);
      #4;
      chk("write_next_cycle", rd_data[XLEN-1:0], 32'hCAFEF00D);
      tick();

      // Readiness of a pending register released in the sampled cycle.
      setIn(1'b1, 1'b1, 5'd4, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
      tick();
      setIn(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 32'h22, '0, 5'd4);
      #4;
`ifdef REGFILE_SB_BYPASS_EN
      chk("bypass_release_ready", {31'b0, rd_ready[1]}, 32'd1);
      chk("bypass_release_data", rd_data[2*XLEN-1:XLEN], 32'h22);
`else
      chk("nobypass_release_ready", {31'b0, rd_ready[1]}, 32'd0);
      chk("nobypass_release_data", rd_data[2*XLEN-1:XLEN], 32'hCAFEF00D);
`endif
      tick();
      idleIn('0, 5'd4);
      #4;
      chk("release_ready", {31'b0, rd_ready[1]}, 32'd1);
      chk("release_data", rd_data[2*XLEN-1:XLEN], 32'h22);
      tick();

      // Fill the scoreboard to its maximum, then drain it.
      for (int r = 1; r < NREGS; r++) begin
         setIn(1'b1, 1'b1, AW'(r), 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
         tick();
      end
      idleIn(5'd31, 5'd1);
      #4;
      chk("full_pend_cnt", {26'b0, pend_cnt}, 32'd31);
      chk("full_ready0", {31'b0, rd_ready[0]}, 32'd0);
      chk("full_ready1", {31'b0, rd_ready[1]}, 32'd0);
      tick();
      for (int r = 1; r < NREGS; r++) begin
         setIn(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, AW'(r), XLEN'(r), '0, '0);
         tick();
      end
      idleIn(5'd31, '0);
      #4;
      chk("drain_pend_cnt", {26'b0, pend_cnt}, 32'd0);
      chk("drain_data", rd_data[XLEN-1:0], 32'd31);
      tick();

      // Random traffic with small address range to force collisions.
      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] amax;
         amax = ($urandom_range(0, 3) == 0) ? AW'(NREGS - 1) : AW'(7);
         setIn(($urandom_range(0, 39) != 0), 1'(($urandom & 1)), AW'($urandom_range(0, amax)),
               1'(($urandom & 1)), AW'($urandom_range(0, amax)), $urandom,
               1'(($urandom & 1)), AW'($urandom_range(0, amax)), $urandom,
               AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax)));
         #4;
         modelCheck();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
